muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M multiply/divide unit for the single-cycle core. It takes the two register-file read values (rs1, rs2 data) and the instruction's funct3. It holds the PC with a stall signal while it iterates, then presents a 32-bit result that the core writes back through the register file's normal write port (write data plus write enable) on the cycle `done` is high. It sits between register read and writeback, in parallel with the ALU.

## Interface
Parameters:
- `XLEN`, 32, datapath width; only 32 is supported.

Ports:
- `clk` in 1: core clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: current instruction is an M-extension op; held by the core for as long as the instruction is held.
- `funct3` in 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op_a` in 32 signed: rs1 data.
- `op_b` in 32 signed: rs2 data.
- `result` out 32 signed: registered result; valid while `done`=1.
- `done` out 1: one-cycle pulse; result is valid and the core must write it back this cycle.
- `busy` out 1: state is not IDLE.
- `stall` out 1: hold the PC and suppress writeback.

## Operation
- State machine: IDLE, MUL, DIV, DONE.
- **IDLE + `start`:** latch `funct3`, `op_a` and `op_b`.
  - Record each sign: sign is applied only for signed operands (op_a for MULH, MULHSU, DIV, REM; op_b for MULH, DIV, REM).
  - Store absolute values.
  - Clear the 6-bit iteration counter.
  - funct3[2]=0 → MUL; funct3[2]=1 → DIV.
- **MUL:** radix-2 shift-add over a 64-bit accumulator, one multiplier bit per cycle.
  - After 32 iterations, negate the 64-bit product if the operand signs differ.
  - Select the low word (MUL) or the high word (MULH, MULHSU, MULHU) into `result`, then go to DONE.
- **DIV:** restoring division, one quotient bit per cycle, 32 iterations.
  - Quotient sign = sign_a XOR sign_b.
  - Remainder sign = sign_a.
  - Select the quotient (DIV, DIVU) or the remainder (REM, REMU), then go to DONE.
- **Special cases:** resolved at the accepting edge, which goes directly to DONE with no iteration.
  - Divide by zero (op_b=0, any div op): quotient = 0xFFFFFFFF; remainder = op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): quotient = 0x80000000; remainder = 0.
- **DONE:** `done`=1 for one cycle, then return to IDLE unconditionally. `start` is ignored while in DONE, because the core is still presenting the same instruction.
- `result` holds its value until the next result is loaded.
- Operands may change after acceptance with no effect.
- No early termination for small operands; latency is fixed.

## Timing
- Reset (async, `rst_n`=0): state=IDLE, counter=0, `result`=0, `done`=0, `busy`=0, `stall`=0. This applies immediately, including mid-iteration; any in-flight operation is discarded.
- `stall` = (IDLE and `start`) or MUL or DIV. It is combinational, so it is high in the cycle `start` first appears.
- Normal op, with the accepting edge called E0:
  - Iteration edges are E1..E32.
  - `done`=1 and `stall`=0 from E32 to E33.
  - The core writes back and advances the PC at E33.
  - `stall` is high for 33 cycles in total.
- Special case: DONE follows E0, so `stall` is high for 1 cycle and `done` is high from E0 to E1.
- `busy` is high from E0 until the edge that leaves DONE.
- Back-to-back M ops: a new `start` is accepted in the IDLE cycle immediately after DONE.

## Structure
- Shared package `riscv_pkg` holds:
  - `XLEN`;
  - enum `muldiv_op_e` for the eight funct3 encodings;
  - enum `muldiv_state_e`;
  - the constants `DIV_BY_ZERO_Q` (0xFFFFFFFF) and `INT_MIN` (0x80000000).
- One sub-module, `muldiv_iter`: the shared 64-bit shift/accumulate datapath. It performs one step per enable, in add mode for multiply and in subtract-and-restore mode for divide.
- The FSM, sign handling and special-case detection stay in `muldiv_unit`.

## Test plan
- MUL, op_a=7, op_b=0xFFFFFFFD → `result`=0xFFFFFFEB; `stall` high exactly 33 cycles; `done` pulses once, 32 edges after acceptance.
- MULH, MULHU and MULHSU with op_a=op_b=0xFFFFFFFF → 0x00000000, 0xFFFFFFFE and 0xFFFFFFFF respectively.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5; each has `stall` high 1 cycle and `done` one edge after acceptance.
- DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0; both take the 1-cycle path.
- Assert `rst_n`=0 during iteration 10 of a MUL:
  - `busy`, `stall`, `done` and `result` go to 0 immediately, without waiting for a clock edge.
  - After release, MUL 3×4 → 12 with normal 33-cycle timing.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32 definitions used by the multiply/divide unit: widths, op/state
// encodings, special-case constants and a conditional-negate helper.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DIV  = 2'b10,
    ST_DONE = 2'b11
  } muldiv_state_e;

  localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  function automatic logic [31:0] cneg32(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

  function automatic logic [63:0] cneg64(input logic [63:0] v, input logic neg);
    return neg ? (64'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared 64-bit shift/accumulate datapath: one shift-add multiply step or one
// restoring-division step per enable. acc_next exposes the post-step value.
module muldiv_iter
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              en,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   load_a,
  input  logic [XLEN-1:0]   load_b,
  output logic [2*XLEN-1:0] acc_next
);

  logic [63:0] acc_r;
  logic [31:0] b_r;
  logic [32:0] sum_s;
  logic [32:0] rem_sh_s;
  logic [32:0] diff_s;

  // one iteration step; divide keeps the partial remainder in the upper half
  always_comb begin
    sum_s    = 33'd0;
    rem_sh_s = 33'd0;
    diff_s   = 33'd0;
    acc_next = acc_r;
    if (div_mode) begin
      rem_sh_s = acc_r[63:31];
      diff_s   = rem_sh_s - {1'b0, b_r};
      if (rem_sh_s >= {1'b0, b_r}) begin
        acc_next = {diff_s[31:0], acc_r[30:0], 1'b1};
      end else begin
        acc_next = {rem_sh_s[31:0], acc_r[30:0], 1'b0};
      end
    end else begin
      sum_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, b_r} : 33'd0);
      acc_next = {sum_s, acc_r[31:1]};
    end
  end

  // accumulator and divisor/multiplicand registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= 64'd0;
      b_r   <= 32'd0;
    end else if (load) begin
      acc_r <= {32'd0, load_a};
      b_r   <= load_b;
    end else if (en) begin
      acc_r <= acc_next;
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add multiply and
// restoring divide, with divide-by-zero and signed overflow resolved at accept.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result,
  output logic            done,
  output logic            busy,
  output logic            stall
);
  import riscv_pkg::*;

  muldiv_state_e state_r, state_next_s;
  logic [5:0]  cnt_r;
  logic [2:0]  funct3_r;
  logic        sign_a_r, sign_b_r;
  logic [31:0] result_r;

  logic        accept_s, step_s, last_iter_s, special_s;
  logic        a_signed_s, b_signed_s, div_zero_s, div_ovf_s;
  logic [31:0] abs_a_s, abs_b_s, special_val_s, final_s;
  logic [63:0] acc_next_s, prod_s;

  // operand decode and special-case detection at acceptance
  always_comb begin
    a_signed_s = 1'b0;
    b_signed_s = 1'b0;
    case (muldiv_op_e'(funct3))
      OP_MULH, OP_DIV, OP_REM: begin
        a_signed_s = 1'b1;
        b_signed_s = 1'b1;
      end
      OP_MULHSU: a_signed_s = 1'b1;
      default: begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
      end
    endcase
    accept_s   = (state_r == ST_IDLE) && start;
    div_zero_s = funct3[2] && (op_b == 32'd0);
    div_ovf_s  = funct3[2] && !funct3[0] && (op_a == INT_MIN) && (op_b == 32'hFFFF_FFFF);
    special_s  = div_zero_s || div_ovf_s;
    abs_a_s    = cneg32(op_a, a_signed_s && op_a[31]);
    abs_b_s    = cneg32(op_b, b_signed_s && op_b[31]);
    if (div_zero_s) begin
      special_val_s = funct3[1] ? op_a : DIV_BY_ZERO_Q;
    end else begin
      special_val_s = funct3[1] ? 32'd0 : INT_MIN;
    end
  end

  // sign fix-up and word select on the final iteration
  always_comb begin
    step_s      = (state_r == ST_MUL) || (state_r == ST_DIV);
    last_iter_s = step_s && (cnt_r == 6'd31);
    prod_s      = cneg64(acc_next_s, sign_a_r ^ sign_b_r);
    if (state_r == ST_DIV) begin
      final_s = funct3_r[1] ? cneg32(acc_next_s[63:32], sign_a_r)
                            : cneg32(acc_next_s[31:0], sign_a_r ^ sign_b_r);
    end else begin
      final_s = (funct3_r == 3'b000) ? prod_s[31:0] : prod_s[63:32];
    end
  end

  muldiv_iter u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept_s),
    .en       (step_s),
    .div_mode (state_r == ST_DIV),
    .load_a   (abs_a_s),
    .load_b   (abs_b_s),
    .acc_next (acc_next_s)
  );

  // next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          if (special_s)      state_next_s = ST_DONE;
          else if (funct3[2]) state_next_s = ST_DIV;
          else                state_next_s = ST_MUL;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_MUL, ST_DIV: begin
        if (last_iter_s) state_next_s = ST_DONE;
        else             state_next_s = state_r;
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // operation context, iteration counter and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r    <= 6'd0;
      funct3_r <= 3'd0;
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      result_r <= 32'd0;
    end else if (accept_s) begin
      cnt_r    <= 6'd0;
      funct3_r <= funct3;
      sign_a_r <= a_signed_s && op_a[31];
      sign_b_r <= b_signed_s && op_b[31];
      if (special_s) result_r <= special_val_s;
    end else if (step_s) begin
      cnt_r <= cnt_r + 6'd1;
      if (last_iter_s) result_r <= final_s;
    end
  end

  assign result = result_r;
  assign done   = (state_r == ST_DONE);
  assign busy   = (state_r != ST_IDLE);
  assign stall  = ((state_r == ST_IDLE) && start) || step_s;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases, async reset
// mid-iteration, and randomized ops against a plain-arithmetic reference.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic [31:0] result;
  logic        done, busy, stall;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .result(result),
    .done(done), .busy(busy), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  // RV32M semantics with 64-bit arithmetic
  function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'sd0;
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (is_special(f, a, b)) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (is_special(f, a, b)) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int edges;
    int stall_cnt;
    bit seen;
    logic [31:0] exp;
    int exp_cycles;
    exp        = ref_model(f, a, b);
    exp_cycles = is_special(f, a, b) ? 1 : 33;
    @(negedge clk);
    start = 1'b1; funct3 = f; op_a = a; op_b = b;
    edges = 0; stall_cnt = 0; seen = 1'b0;
    while (!seen && edges < 60) begin
      #1;
      if (stall === 1'b1) stall_cnt++;
      @(posedge clk);
      #1;
      edges++;
      if (edges == 1) begin
        check($sformatf("busy_after_accept f%0d", f), {31'd0, busy}, 32'd1);
        op_a = $urandom;
        op_b = $urandom;
      end
      if (done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    check($sformatf("done_seen f%0d", f), {31'd0, seen}, 32'd1);
    check($sformatf("result f%0d a=%h b=%h", f, a, b), result, exp);
    check($sformatf("stall_cycles f%0d", f), stall_cnt, exp_cycles);
    check($sformatf("done_edges f%0d", f), edges, exp_cycles);
    check($sformatf("stall_at_done f%0d", f), {31'd0, stall}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check($sformatf("done_pulse f%0d", f), {30'd0, done, busy}, 32'd0);
    check($sformatf("result_hold f%0d", f), result, exp);
  endtask

  initial begin
    logic [31:0] ra, rb;
    #1;
    check("reset_outputs", {28'd0, done, busy, stall, 1'b0}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd5, 32'd5, 32'd0);
    run_op(3'd7, 32'd5, 32'd0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd1, 32'h1234_5678, 32'hFEDC_BA98);

    // async reset in the middle of a multiply
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'hDEAD_BEEF; op_b = 32'h0BAD_F00D;
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    check("async_reset_flags", {29'd0, busy, stall, done}, 32'd0);
    check("async_reset_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(3'd0, 32'd3, 32'd4);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = $urandom_range(0, 100);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = $urandom_range(1, 50);
        default: rb = $urandom;
      endcase
      run_op(3'($urandom_range(0, 7)), ra, rb);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
